// File: rtl/aesl_deadlock_origin_arbiter.sv
// aesl_deadlock_origin_arbiter: elects and confirms the deadlock origin process; optional DL_ORIGIN_REPORT_EN adds sim messages and auto-finish
module aesl_deadlock_origin_arbiter #(
    parameter int PROC_NUM       = 2,
    parameter int CONFIRM_CYCLES = 4,
    parameter int IDX_W          = 1,
    parameter int CNT_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec_i,
    output logic                dl_detect_out_o,
    output logic [PROC_NUM-1:0] origin_o,
    output logic                token_clear_o,
    output logic                dl_report_vld_o,
    output logic [IDX_W-1:0]    dl_origin_idx_o,
    output logic [CNT_W-1:0]    abort_count_o
);
    localparam int CW = $clog2(CONFIRM_CYCLES + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CLEAR = 2'd2, DETECTED = 2'd3} state_t;
    state_t              state_q, state_d;
    logic [PROC_NUM-1:0] origin_q, origin_d, low_oh;
    logic [IDX_W-1:0]    idx_q, idx_d, low_idx;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]    abort_q, abort_d;
    logic                det_q, det_d, tclr_q, tclr_d, vld_q, vld_d;
    // lowest-index candidate wins when several units flag at once
    always_comb begin
        low_oh  = '0;
        low_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_in_vec_i[i]) begin
                low_oh    = '0;
                low_oh[i] = 1'b1;
                low_idx   = IDX_W'(i);
            end
        end
    end
    // election / confirmation / abort sequencing; every output is a register
    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        det_d    = det_q;
        tclr_d   = 1'b0;
        vld_d    = 1'b0;
        case (state_q)
            IDLE: begin
                origin_d = '0;
                if (|dl_in_vec_i) begin
                    origin_d = low_oh;
                    idx_d    = low_idx;
                    cnt_d    = CW'(1);
                    state_d  = ARM;
                end
            end
            ARM: begin
                if (dl_in_vec_i[idx_q]) begin
                    if (cnt_q >= CW'(CONFIRM_CYCLES)) begin
                        state_d = DETECTED;
                        det_d   = 1'b1;
                        vld_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = CLEAR;
                    tclr_d  = 1'b1;
                    abort_d = &abort_q ? abort_q : abort_q + 1'b1;
                end
            end
            CLEAR: begin
                origin_d = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            DETECTED: state_d = DETECTED;
            default: begin
                origin_d = '0;
                det_d    = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end
    // state and output registers, cleared immediately by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            origin_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            abort_q  <= '0;
            det_q    <= 1'b0;
            tclr_q   <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            det_q    <= det_d;
            tclr_q   <= tclr_d;
            vld_q    <= vld_d;
        end
    end
    assign dl_detect_out_o = det_q;
    assign origin_o        = origin_q;
    assign token_clear_o   = tclr_q;
    assign dl_report_vld_o = vld_q;
    assign dl_origin_idx_o = idx_q;
    assign abort_count_o   = abort_q;
`ifdef DL_ORIGIN_REPORT_EN
    logic [4:0] fin_q;
    // end the simulation a fixed while after the deadlock is confirmed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fin_q <= '0;
        else if (state_q == DETECTED) begin
            fin_q <= fin_q + 1'b1;
            if (fin_q == 5'd15) $finish;
        end
    end
    // human-readable trace of confirmed and aborted candidates
    always @(posedge clock) begin
        if (reset && state_q == ARM && state_d == DETECTED)
            $display("DEADLOCK: origin process %0d at %0t", idx_q, $time);
        if (reset && tclr_q) $display("deadlock candidate %0d aborted", idx_q);
    end
`endif
endmodule

// File: tb/tb_aesl_deadlock_origin_arbiter.sv
// tb_aesl_deadlock_origin_arbiter: vector table, corner sequences and randomized model comparison
module tb_aesl_deadlock_origin_arbiter;
    localparam int C = 4;
    logic       clock = 1'b0, reset = 1'b0;
    logic [1:0] vec = 2'b00;
    logic       det, tclr, vld;
    logic [1:0] origin;
    logic [0:0] idx;
    logic [7:0] abort;
    int total = 0, passed = 0;

    aesl_deadlock_origin_arbiter #(.PROC_NUM(2), .CONFIRM_CYCLES(C), .IDX_W(1), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .dl_in_vec_i(vec), .dl_detect_out_o(det), .origin_o(origin),
        .token_clear_o(tclr), .dl_report_vld_o(vld), .dl_origin_idx_o(idx), .abort_count_o(abort));

    always #5 clock = ~clock;

    typedef struct {
        logic rst; logic [1:0] vec; logic [1:0] o; logic i; logic d; logic c; logic v; logic [7:0] a;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(string nm, logic [1:0] eo, logic ei, logic ed, logic ec, logic ev, logic [7:0] ea);
        logic ai, xi;
        ai = (eo != 2'b00) ? idx[0] : 1'b0;
        xi = (eo != 2'b00) ? ei : 1'b0;
        total++;
        if ({origin, ai, det, tclr, vld, abort} === {eo, xi, ed, ec, ev, ea}) passed++;
        else $display("FAIL %s: got origin=%b idx=%b det=%b clr=%b vld=%b abort=%0d, want origin=%b idx=%b det=%b clr=%b vld=%b abort=%0d",
                      nm, origin, ai, det, tclr, vld, abort, eo, xi, ed, ec, ev, ea);
    endtask

    task automatic chk_val(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic step(logic r, logic [1:0] v);
        reset = ~r;
        vec   = v;
        @(posedge clock);
        #1;
    endtask

    // reference: a candidate is confirmed after C+1 consecutive high samples of its own flag
    int m_cand = -1, m_streak = 0, m_ab = 0;
    bit m_det = 0, m_clr = 0, m_tc = 0, m_vl = 0;
    function automatic void model(bit r, logic [1:0] v);
        m_tc = 0;
        m_vl = 0;
        if (r) begin
            m_cand = -1; m_streak = 0; m_ab = 0; m_det = 0; m_clr = 0;
        end else if (m_det) begin
        end else if (m_clr) begin
            m_clr  = 0;
            m_cand = -1;
        end else if (m_cand < 0) begin
            if (v != 2'b00) begin
                for (int i = 1; i >= 0; i--) if (v[i]) m_cand = i;
                m_streak = 1;
            end
        end else if (v[m_cand]) begin
            m_streak++;
            if (m_streak > C) begin
                m_det = 1;
                m_vl  = 1;
            end
        end else begin
            m_ab  = (m_ab < 255) ? m_ab + 1 : 255;
            m_clr = 1;
            m_tc  = 1;
        end
    endfunction

    initial begin
        int tc_cnt;
        logic [1:0] v;
        bit r;
        repeat (2) @(posedge clock);
        #1;
        chk("reset", 2'b00, 1'b0, 0, 0, 0, 8'd0);
        for (int k = 0; k < 20; k++) begin
            step(0, 2'b00);
            chk("idle", 2'b00, 1'b0, 0, 0, 0, 8'd0);
        end

        for (int k = 0; k < 4; k++) tbl.push_back('{0, 2'b10, 2'b10, 1, 0, 0, 0, 8'd0});
        tbl.push_back('{0, 2'b10, 2'b10, 1, 1, 0, 1, 8'd0});
        tbl.push_back('{0, 2'b00, 2'b10, 1, 1, 0, 0, 8'd0});
        tbl.push_back('{0, 2'b01, 2'b10, 1, 1, 0, 0, 8'd0});
        tbl.push_back('{1, 2'b00, 2'b00, 0, 0, 0, 0, 8'd0});
        tbl.push_back('{0, 2'b11, 2'b01, 0, 0, 0, 0, 8'd0});
        for (int k = 0; k < 3; k++) tbl.push_back('{0, 2'b01, 2'b01, 0, 0, 0, 0, 8'd0});
        tbl.push_back('{0, 2'b01, 2'b01, 0, 1, 0, 1, 8'd0});
        tbl.push_back('{0, 2'b00, 2'b01, 0, 1, 0, 0, 8'd0});
        tbl.push_back('{1, 2'b00, 2'b00, 0, 0, 0, 0, 8'd0});
        tbl.push_back('{0, 2'b01, 2'b01, 0, 0, 0, 0, 8'd0});
        tbl.push_back('{0, 2'b01, 2'b01, 0, 0, 0, 0, 8'd0});
        tbl.push_back('{0, 2'b00, 2'b01, 0, 0, 1, 0, 8'd1});
        tbl.push_back('{0, 2'b00, 2'b00, 0, 0, 0, 0, 8'd1});
        tbl.push_back('{0, 2'b10, 2'b10, 1, 0, 0, 0, 8'd1});
        tbl.push_back('{0, 2'b00, 2'b10, 1, 0, 1, 0, 8'd2});
        tbl.push_back('{0, 2'b01, 2'b00, 0, 0, 0, 0, 8'd2});
        tbl.push_back('{0, 2'b01, 2'b01, 0, 0, 0, 0, 8'd2});
        tbl.push_back('{1, 2'b00, 2'b00, 0, 0, 0, 0, 8'd0});
        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].vec);
            chk($sformatf("vec%0d", k), tbl[k].o, tbl[k].i, tbl[k].d, tbl[k].c, tbl[k].v, tbl[k].a);
        end

        step(0, 2'b10);
        step(0, 2'b10);
        chk("arm_hold", 2'b10, 1'b1, 0, 0, 0, 8'd0);
        #2 reset = 1'b0;
        #1 chk("async_arm", 2'b00, 1'b0, 0, 0, 0, 8'd0);
        @(posedge clock);
        #1 chk("arm_rst_noclr", 2'b00, 1'b0, 0, 0, 0, 8'd0);
        step(0, 2'b01);
        chk("re_elect", 2'b01, 1'b0, 0, 0, 0, 8'd0);
        repeat (3) step(0, 2'b01);
        chk("pre_det", 2'b01, 1'b0, 0, 0, 0, 8'd0);
        step(0, 2'b01);
        chk("det", 2'b01, 1'b0, 1, 0, 1, 8'd0);
        #2 reset = 1'b0;
        #1 chk("async_det", 2'b00, 1'b0, 0, 0, 0, 8'd0);
        @(posedge clock);
        #1 chk("det_rst_noclr", 2'b00, 1'b0, 0, 0, 0, 8'd0);
        step(0, 2'b00);

        tc_cnt = 0;
        for (int k = 1; k <= 300; k++) begin
            step(0, 2'b01);
            tc_cnt += int'(tclr);
            step(0, 2'b00);
            tc_cnt += int'(tclr);
            if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
                chk($sformatf("abort%0d", k), 2'b01, 1'b0, 0, 1, 0, 8'(k > 255 ? 255 : k));
            step(0, 2'b00);
            tc_cnt += int'(tclr);
        end
        chk_val("clear_pulses", tc_cnt, 300);
        chk("sat_idle", 2'b00, 1'b0, 0, 0, 0, 8'd255);

        step(1, 2'b00);
        model(1, 2'b00);
        v = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 3) v = 2'($urandom_range(0, 3));
            step(r, v);
            model(r, v);
            chk("rand", m_cand >= 0 ? 2'(1 << m_cand) : 2'b00, 1'(m_cand), m_det, m_tc, m_vl, 8'(m_ab));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
